// File: rtl/flash_read.sv
`default_nettype none
// ============================================================================
// Module   : flash_read
// Purpose  : SPI NOR read controller. It polls RDSR until the device is ready,
//            then issues READ and streams the returned bytes to the user side.
//            Define FLASH_FAST_READ_EN for opcode 0x0B plus one dummy byte.
// Revision : 1.0 - initial release
// ============================================================================
module flash_read #(
    parameter logic [7:0] CMD_READ = 8'h03,
    parameter logic [7:0] CMD_RDSR = 8'h05,
    parameter int         POLL_MAX = 16,
    parameter int         GAP_CYC  = 50,
    parameter int         LEN_W    = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rden,
    input  logic [23:0]      rd_addr,
    input  logic [LEN_W-1:0] rd_len,
    output logic [7:0]       rddata,
    output logic             rddata_vld,
    output logic             rddone,
    output logic             rdbusy,
    output logic [1:0]       fail,
    output logic             req,
    output logic [7:0]       din,
    input  logic             done,
    input  logic [7:0]       dout,
    output logic             finish
);

`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] c_RD_OP = 8'h0B;
    localparam int         c_HDR   = 5;
`else
    localparam logic [7:0] c_RD_OP = CMD_READ;
    localparam int         c_HDR   = 4;
`endif

    localparam int BC_W = LEN_W + 1;
    localparam int PC_W = $clog2(POLL_MAX + 1);
    localparam int GC_W = $clog2(GAP_CYC + 1);

    localparam logic [GC_W-1:0] c_GAP_LAST = GC_W'(GAP_CYC - 1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_POLL = 3'd1;
    localparam logic [2:0] c_GAP  = 3'd2;
    localparam logic [2:0] c_READ = 3'd3;
    localparam logic [2:0] c_END  = 3'd4;

    logic [2:0]      state_q,    state_d;
    logic [23:0]     addr_q,     addr_d;
    logic [BC_W-1:0] total_q,    total_d;
    logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [PC_W-1:0] poll_cnt_q, poll_cnt_d;
    logic [GC_W-1:0] gap_cnt_q,  gap_cnt_d;
    logic            wip_q,      wip_d;
    logic            outst_q,    outst_d;
    logic [7:0]      rddata_q,   rddata_d;
    logic            vld_q,      vld_d;
    logic            rddone_q,   rddone_d;
    logic            rdbusy_q,   rdbusy_d;
    logic [1:0]      fail_q,     fail_d;
    logic            req_q,      req_d;
    logic [7:0]      din_q,      din_d;
    logic            finish_q,   finish_d;

    logic            w_done_ok;
    logic            w_gap_end;
    logic            w_poll_left;
    logic [BC_W-1:0] w_byte_nxt;
    logic            w_last;
    logic            w_data_phase;
    logic [7:0]      w_read_byte;

    // A done only counts when a byte is actually outstanding.
    assign w_done_ok    = done && outst_q;
    assign w_gap_end    = (gap_cnt_q == c_GAP_LAST);
    assign w_poll_left  = (poll_cnt_q < PC_W'(POLL_MAX));
    assign w_byte_nxt   = byte_cnt_q + BC_W'(1);
    assign w_last       = (w_byte_nxt == total_q);
    assign w_data_phase = (byte_cnt_q >= BC_W'(c_HDR));

    always_comb begin
        w_read_byte = 8'h00;
        case (w_byte_nxt)
            BC_W'(1): w_read_byte = addr_q[23:16];
            BC_W'(2): w_read_byte = addr_q[15:8];
            BC_W'(3): w_read_byte = addr_q[7:0];
            default:  w_read_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= c_IDLE;
            addr_q     <= '0;
            total_q    <= '0;
            byte_cnt_q <= '0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            wip_q      <= 1'b0;
            outst_q    <= 1'b0;
            rddata_q   <= '0;
            vld_q      <= 1'b0;
            rddone_q   <= 1'b0;
            rdbusy_q   <= 1'b0;
            fail_q     <= '0;
            req_q      <= 1'b0;
            din_q      <= '0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            total_q    <= total_d;
            byte_cnt_q <= byte_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            wip_q      <= wip_d;
            outst_q    <= outst_d;
            rddata_q   <= rddata_d;
            vld_q      <= vld_d;
            rddone_q   <= rddone_d;
            rdbusy_q   <= rdbusy_d;
            fail_q     <= fail_d;
            req_q      <= req_d;
            din_q      <= din_d;
            finish_q   <= finish_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: if (rden && (rd_len != '0)) state_d = c_POLL;
            c_POLL: if (w_done_ok && (byte_cnt_q != '0)) state_d = c_GAP;
            c_GAP: begin
                if (w_gap_end) begin
                    if (!wip_q)           state_d = c_READ;
                    else if (w_poll_left) state_d = c_POLL;
                    else                  state_d = c_IDLE;
                end
            end
            c_READ: if (w_done_ok && w_last) state_d = c_END;
            c_END:  if (gap_cnt_q != '0) state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // All outputs are registered: this block computes their next values.
    always_comb begin
        addr_d     = addr_q;
        total_d    = total_q;
        byte_cnt_d = byte_cnt_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        wip_d      = wip_q;
        outst_d    = outst_q;
        rddata_d   = rddata_q;
        vld_d      = 1'b0;
        rddone_d   = 1'b0;
        rdbusy_d   = rdbusy_q;
        fail_d     = 2'b00;
        req_d      = 1'b0;
        din_d      = 8'h00;
        finish_d   = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (rden) begin
                    if (rd_len == '0) begin
                        fail_d = 2'b10;
                    end else begin
                        addr_d     = rd_addr;
                        total_d    = BC_W'(rd_len) + BC_W'(c_HDR);
                        rdbusy_d   = 1'b1;
                        poll_cnt_d = '0;
                        byte_cnt_d = '0;
                        gap_cnt_d  = '0;
                        req_d      = 1'b1;
                        din_d      = CMD_RDSR;
                        outst_d    = 1'b1;
                    end
                end
            end
            c_POLL: begin
                if (w_done_ok) begin
                    outst_d = 1'b0;
                    if (byte_cnt_q == '0) begin
                        byte_cnt_d = BC_W'(1);
                        req_d      = 1'b1;
                        din_d      = 8'h00;
                        outst_d    = 1'b1;
                    end else begin
                        byte_cnt_d = '0;
                        wip_d      = dout[0];
                        poll_cnt_d = poll_cnt_q + PC_W'(1);
                        finish_d   = 1'b1;
                        gap_cnt_d  = '0;
                    end
                end
            end
            c_GAP: begin
                gap_cnt_d = gap_cnt_q + GC_W'(1);
                if (w_gap_end) begin
                    gap_cnt_d  = '0;
                    byte_cnt_d = '0;
                    if (!wip_q) begin
                        req_d   = 1'b1;
                        din_d   = c_RD_OP;
                        outst_d = 1'b1;
                    end else if (w_poll_left) begin
                        req_d   = 1'b1;
                        din_d   = CMD_RDSR;
                        outst_d = 1'b1;
                    end else begin
                        fail_d   = 2'b01;
                        rdbusy_d = 1'b0;
                    end
                end
            end
            c_READ: begin
                if (w_done_ok) begin
                    outst_d    = 1'b0;
                    byte_cnt_d = w_byte_nxt;
                    if (w_data_phase) begin
                        vld_d    = 1'b1;
                        rddata_d = dout;
                    end
                    if (!w_last) begin
                        req_d   = 1'b1;
                        din_d   = w_read_byte;
                        outst_d = 1'b1;
                    end
                end
            end
            c_END: begin
                // First END cycle raises finish, the second reports rddone.
                if (gap_cnt_q == '0) begin
                    finish_d  = 1'b1;
                    gap_cnt_d = GC_W'(1);
                end else begin
                    rddone_d  = 1'b1;
                    rdbusy_d  = 1'b0;
                    gap_cnt_d = '0;
                end
            end
            default: begin
                rdbusy_d = 1'b0;
            end
        endcase
    end

    assign rddata     = rddata_q;
    assign rddata_vld = vld_q;
    assign rddone     = rddone_q;
    assign rdbusy     = rdbusy_q;
    assign fail       = fail_q;
    assign req        = req_q;
    assign din        = din_q;
    assign finish     = finish_q;

endmodule
`default_nettype wire

// File: tb/tb_flash_read.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_read
// Purpose  : Directed bench for flash_read with an SPI byte-master model and a
//            queue-based reference of the expected byte and data streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flash_read;

    localparam int GAP_CYC  = 50;
    localparam int POLL_MAX = 16;
    localparam int LEN_W    = 11;
`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] RD_OP = 8'h0B;
    localparam int         HDR   = 5;
    localparam int         LIT_N = 11;
    logic [7:0] lit_basic [0:LIT_N-1] = '{8'h05, 8'h00, 8'h0B, 8'h00, 8'h01, 8'h00,
                                          8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    localparam logic [7:0] RD_OP = 8'h03;
    localparam int         HDR   = 4;
    localparam int         LIT_N = 10;
    logic [7:0] lit_basic [0:LIT_N-1] = '{8'h05, 8'h00, 8'h03, 8'h00, 8'h01, 8'h00,
                                          8'h00, 8'h00, 8'h00, 8'h00};
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rden;
    logic [23:0]      rd_addr;
    logic [LEN_W-1:0] rd_len;
    logic [7:0]       rddata;
    logic             rddata_vld;
    logic             rddone;
    logic             rdbusy;
    logic [1:0]       fail;
    logic             req;
    logic [7:0]       din;
    logic             done;
    logic [7:0]       dout;
    logic             finish;

    flash_read #(
        .CMD_READ (8'h03),
        .CMD_RDSR (8'h05),
        .POLL_MAX (POLL_MAX),
        .GAP_CYC  (GAP_CYC),
        .LEN_W    (LEN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rden       (rden),
        .rd_addr    (rd_addr),
        .rd_len     (rd_len),
        .rddata     (rddata),
        .rddata_vld (rddata_vld),
        .rddone     (rddone),
        .rdbusy     (rdbusy),
        .fail       (fail),
        .req        (req),
        .din        (din),
        .done       (done),
        .dout       (dout),
        .finish     (finish)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [7:0] exp_din  [$];
    logic [7:0] exp_data [$];
    logic [1:0] exp_fail = 2'b00;
    logic [7:0] din_log  [$];
    logic [7:0] data_log [$];
    int rddone_cnt = 0, fail_cnt = 0, finish_cnt = 0, vld_cnt = 0;

    // SPI master model stimulus
    logic [7:0] st_q [$];
    logic [7:0] st_default = 8'h00;
    logic [7:0] dat_mem [0:15];
    bit         spur = 1'b0;

    initial begin : master
        int         pos;
        int         lat;
        bit         pend;
        logic [7:0] first;
        logic [7:0] resp;
        pos = 0; lat = 0; pend = 1'b0; first = 8'h00; resp = 8'h00;
        done = 1'b0; dout = 8'h00;
        forever begin
            @(posedge clk); #1;
            done = 1'b0;
            if (!rst_n) begin
                pos = 0; pend = 1'b0;
            end else begin
                if (pend) begin
                    if (lat == 0) begin
                        done = 1'b1; dout = resp; pend = 1'b0;
                    end else begin
                        lat--;
                    end
                end else if (spur) begin
                    done = 1'b1; dout = 8'h00; spur = 1'b0;
                end
                if (finish) pos = 0;
                if (req) begin
                    if (pos == 0) first = din;
                    if (first == 8'h05 && pos == 1)
                        resp = (st_q.size() > 0) ? st_q.pop_front() : st_default;
                    else if (first == RD_OP && pos >= HDR)
                        resp = dat_mem[(pos - HDR) % 16];
                    else
                        resp = 8'hA5;
                    pos++; pend = 1'b1; lat = 1;
                end
            end
        end
    end

    // Per-cycle compare against the reference queues and handshake timing
    initial begin : compare
        bit         in_txn, outst, gap_pend;
        int         last_done, last_fin, last_vld;
        logic [7:0] txn_first;
        in_txn = 0; outst = 0; gap_pend = 0;
        last_done = 0; last_fin = 0; last_vld = 0; txn_first = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_txn = 0; outst = 0; gap_pend = 0;
            end else begin
                if (rden) gap_pend = 0;
                if (done && outst) begin
                    last_done = cyc; outst = 0;
                end
                if (req) begin
                    chk("one_outstanding", {31'b0, outst}, 0);
                    if (exp_din.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL din_unexpected: got req with din=%02h, required no request", din);
                    end else begin
                        chk("din", din, exp_din.pop_front());
                    end
                    din_log.push_back(din);
                    if (in_txn) begin
                        chk("req_after_done", cyc - last_done, 1);
                    end else begin
                        if (gap_pend) chk("gap_len", cyc - last_fin, GAP_CYC);
                        txn_first = din; in_txn = 1;
                    end
                    outst = 1;
                end
                if (rddata_vld) begin
                    vld_cnt++; last_vld = cyc;
                    data_log.push_back(rddata);
                    chk("vld_after_done", cyc - last_done, 1);
                    if (exp_data.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL rddata_unexpected: got %02h, required no data", rddata);
                    end else begin
                        chk("rddata", rddata, exp_data.pop_front());
                    end
                end
                if (finish) begin
                    finish_cnt++; in_txn = 0; last_fin = cyc;
                    if (txn_first == 8'h05) begin
                        chk("fin_poll_lat", cyc - last_done, 1);
                        gap_pend = 1;
                    end else begin
                        chk("fin_read_lat", cyc - last_done, 2);
                        chk("fin_after_vld", cyc - last_vld, 1);
                    end
                end
                if (rddone) begin
                    rddone_cnt++;
                    chk("rddone_lat", cyc - last_fin, 1);
                    chk("busy_at_rddone", {31'b0, rdbusy}, 0);
                end
                if (fail != 2'b00) begin
                    fail_cnt++; gap_pend = 0;
                    chk("fail_code", {30'b0, fail}, {30'b0, exp_fail});
                    chk("busy_at_fail", {31'b0, rdbusy}, 0);
                end
            end
        end
    end

    task automatic push_read(input logic [23:0] a, input int len);
        exp_din.push_back(RD_OP);
        exp_din.push_back(a[23:16]);
        exp_din.push_back(a[15:8]);
        exp_din.push_back(a[7:0]);
        if (HDR == 5) exp_din.push_back(8'h00);
        for (int i = 0; i < len; i++) begin
            exp_din.push_back(8'h00);
            exp_data.push_back(dat_mem[i % 16]);
        end
    endtask

    // Expected traffic: poll until a ready status or POLL_MAX polls, then read.
    task automatic plan(input logic [23:0] a, input int len);
        int         polls;
        bit         ready;
        logic [7:0] s;
        if (len == 0) begin
            exp_fail = 2'b10;
            return;
        end
        polls = 0; ready = 0;
        while (!ready && polls < POLL_MAX) begin
            s = (polls < st_q.size()) ? st_q[polls] : st_default;
            polls++;
            exp_din.push_back(8'h05);
            exp_din.push_back(8'h00);
            ready = (s[0] == 1'b0);
        end
        exp_fail = ready ? 2'b00 : 2'b01;
        if (ready) push_read(a, len);
    endtask

    task automatic pulse_rden(input logic [23:0] a, input logic [LEN_W-1:0] l);
        @(posedge clk); #1;
        rden = 1'b1; rd_addr = a; rd_len = l;
        @(posedge clk); #1;
        rden = 1'b0;
    endtask

    task automatic wait_end(input int base, input string name);
        int n;
        n = 0;
        while ((rddone_cnt + fail_cnt) == base && n < 3000) begin
            @(posedge clk); n++;
        end
        chk({name, "_completed"}, {31'b0, (rddone_cnt + fail_cnt) != base}, 1);
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_vld(input int target);
        int n;
        n = 0;
        while (vld_cnt < target && n < 2000) begin
            @(posedge clk); n++;
        end
        chk("vld_reached", {31'b0, vld_cnt >= target}, 1);
    endtask

    function automatic int count_byte(input int from, input logic [7:0] b);
        int c;
        c = 0;
        for (int i = from; i < din_log.size(); i++) if (din_log[i] == b) c++;
        return c;
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rddata"},  {24'b0, rddata}, 0);
        chk({tag, "_vld"},     {31'b0, rddata_vld}, 0);
        chk({tag, "_rddone"},  {31'b0, rddone}, 0);
        chk({tag, "_rdbusy"},  {31'b0, rdbusy}, 0);
        chk({tag, "_fail"},    {30'b0, fail}, 0);
        chk({tag, "_req"},     {31'b0, req}, 0);
        chk({tag, "_din"},     {24'b0, din}, 0);
        chk({tag, "_finish"},  {31'b0, finish}, 0);
    endtask

    initial begin : main
        int log0, d0, base, dbase, fbase, v0;
        rst_n = 1'b0; rden = 1'b0; rd_addr = '0; rd_len = '0;
        for (int i = 0; i < 16; i++) dat_mem[i] = 8'h00;
        repeat (3) @(posedge clk); #2;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic read
        st_q.delete(); st_q.push_back(8'h00); st_default = 8'h00;
        dat_mem[0] = 8'h11; dat_mem[1] = 8'h22; dat_mem[2] = 8'h33; dat_mem[3] = 8'h44;
        log0 = din_log.size(); d0 = data_log.size();
        base = rddone_cnt + fail_cnt; dbase = rddone_cnt;
        plan(24'h000100, 4);
        pulse_rden(24'h000100, 4);
        wait_end(base, "basic");
        chk("basic_din_left", exp_din.size(), 0);
        chk("basic_data_left", exp_data.size(), 0);
        chk("basic_rddone", rddone_cnt - dbase, 1);
        chk("basic_din_count", din_log.size() - log0, LIT_N);
        for (int i = 0; i < LIT_N; i++)
            if (log0 + i < din_log.size()) chk("basic_lit_din", din_log[log0 + i], lit_basic[i]);
        if (data_log.size() >= d0 + 4) begin
            chk("basic_lit_data0", data_log[d0], 8'h11);
            chk("basic_lit_data3", data_log[d0 + 3], 8'h44);
        end else begin
            chk("basic_data_count", data_log.size() - d0, 4);
        end

        // Busy twice, then ready; a stray done is injected during the gap
        st_q.delete(); st_q.push_back(8'h01); st_q.push_back(8'h01); st_default = 8'h00;
        dat_mem[0] = 8'hA0; dat_mem[1] = 8'hA1; dat_mem[2] = 8'hA2;
        log0 = din_log.size(); base = rddone_cnt + fail_cnt; fbase = fail_cnt;
        plan(24'h123456, 3);
        pulse_rden(24'h123456, 3);
        repeat (20) @(posedge clk);
        spur = 1'b1;
        wait_end(base, "busy");
        chk("busy_din_left", exp_din.size(), 0);
        chk("busy_data_left", exp_data.size(), 0);
        chk("busy_polls", count_byte(log0, 8'h05), 3);
        chk("busy_nofail", fail_cnt - fbase, 0);

        // Timeout: device stays busy
        st_q.delete(); st_default = 8'h01;
        log0 = din_log.size(); base = rddone_cnt + fail_cnt; fbase = fail_cnt;
        plan(24'h000040, 2);
        pulse_rden(24'h000040, 2);
        wait_end(base, "timeout");
        chk("timeout_din_left", exp_din.size(), 0);
        chk("timeout_polls", count_byte(log0, 8'h05), 16);
        chk("timeout_no_read", count_byte(log0, RD_OP), 0);
        chk("timeout_fail_once", fail_cnt - fbase, 1);
        chk("timeout_rdbusy", {31'b0, rdbusy}, 0);

        // Zero length
        st_default = 8'h00;
        log0 = din_log.size(); base = rddone_cnt + fail_cnt; fbase = fail_cnt;
        plan(24'h000500, 0);
        pulse_rden(24'h000500, 0);
        wait_end(base, "zerolen");
        chk("zerolen_no_req", din_log.size() - log0, 0);
        chk("zerolen_fail_once", fail_cnt - fbase, 1);
        chk("zerolen_rdbusy", {31'b0, rdbusy}, 0);

        // Second rden during READ is ignored
        for (int i = 0; i < 6; i++) dat_mem[i] = 8'h60 + 8'(i);
        base = rddone_cnt + fail_cnt; dbase = rddone_cnt; v0 = vld_cnt;
        plan(24'h00ABCD, 6);
        pulse_rden(24'h00ABCD, 6);
        wait_vld(v0 + 1);
        pulse_rden(24'hFFFF00, 2);
        wait_end(base, "ignored");
        repeat (100) @(posedge clk);
        chk("ignored_din_left", exp_din.size(), 0);
        chk("ignored_data_left", exp_data.size(), 0);
        chk("ignored_rddone_once", rddone_cnt - dbase, 1);

        // Reset in the data phase after two of eight bytes
        for (int i = 0; i < 8; i++) dat_mem[i] = 8'h70 + 8'(i);
        v0 = vld_cnt;
        plan(24'h000200, 8);
        pulse_rden(24'h000200, 8);
        wait_vld(v0 + 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        exp_din.delete(); exp_data.delete(); exp_fail = 2'b00;
        repeat (3) @(posedge clk); #2;
        rst_n = 1'b1;
        dat_mem[0] = 8'h80; dat_mem[1] = 8'h81;
        log0 = din_log.size(); base = rddone_cnt + fail_cnt; dbase = rddone_cnt;
        plan(24'h000300, 2);
        pulse_rden(24'h000300, 2);
        wait_end(base, "restart");
        if (din_log.size() > log0) chk("restart_first_din", din_log[log0], 8'h05);
        else chk("restart_req_count", din_log.size() - log0, 2 + HDR + 2);
        chk("restart_din_left", exp_din.size(), 0);
        chk("restart_data_left", exp_data.size(), 0);
        chk("restart_rddone", rddone_cnt - dbase, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
